// File: rtl/pc_sequencer.sv
// Program-counter sequencer for IF1: picks the next PC (sequential, redirect,
// held redirect or WFI resume) and drives the PC register load enable.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_if1,
  input  logic [31:0] current_pc_if1,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        mret_redirect,
  input  logic [31:0] mepc,
  input  logic        trap_valid,
  input  logic [31:0] trap_vector,
  input  logic        wfi_req,
  input  logic        irq_pending,
  output logic        pc_en,
  output logic [31:0] next_pc_if1,
  output logic        flush_if,
  output logic        redirect_pending,
  output logic        wfi_active
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, WFI} state_t;

  state_t      state, state_nxt;
  logic [31:0] pend_pc, pend_nxt;
  logic        any_redirect;
  logic [31:0] sel_target, seq_pc, trap_aligned;

  assign any_redirect = trap_valid | mret_redirect | br_redirect;
  assign seq_pc       = current_pc_if1 + PC_STEP;
  assign trap_aligned = {trap_vector[31:2], 2'b00};

  // Priority trap > mret > branch; targets are always word aligned.
  always_comb begin
    if (trap_valid)         sel_target = trap_aligned;
    else if (mret_redirect) sel_target = {mepc[31:2], 2'b00};
    else                    sel_target = {br_target[31:2], 2'b00};
  end

  always_comb begin
    state_nxt        = state;
    pend_nxt         = pend_pc;
    pc_en            = 1'b0;
    next_pc_if1      = seq_pc;
    flush_if         = 1'b0;
    redirect_pending = 1'b0;
    wfi_active       = 1'b0;
    case (state)
      BOOT: begin
        next_pc_if1 = RESET_VECTOR;
        state_nxt   = RUN;
      end
      RUN: begin
        if (any_redirect) begin
          flush_if = 1'b1;
          if (stall_if1) begin
            pend_nxt  = sel_target;
            state_nxt = HOLD;
          end else begin
            pc_en       = 1'b1;
            next_pc_if1 = sel_target;
          end
        end else if (wfi_req) begin
          state_nxt = WFI;
        end else if (!stall_if1) begin
          pc_en = 1'b1;
        end
      end
      HOLD: begin
        next_pc_if1 = pend_pc;
        if (stall_if1) begin
          redirect_pending = 1'b1;
          if (any_redirect) begin
            flush_if = 1'b1;
            pend_nxt = sel_target;
          end
        end else begin
          // A fresh redirect at release supersedes the held one.
          pc_en     = 1'b1;
          state_nxt = RUN;
          if (any_redirect) begin
            flush_if    = 1'b1;
            next_pc_if1 = sel_target;
          end
        end
      end
      WFI: begin
        wfi_active = 1'b1;
        if (trap_valid) begin
          flush_if = 1'b1;
          if (stall_if1) begin
            pend_nxt  = trap_aligned;
            state_nxt = HOLD;
          end else begin
            pc_en       = 1'b1;
            next_pc_if1 = trap_aligned;
            state_nxt   = RUN;
          end
        end else if (irq_pending) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= BOOT;
      pend_pc <= 32'h0;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register closing the loop.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_if1;
  logic [31:0] current_pc_if1;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        mret_redirect;
  logic [31:0] mepc;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        wfi_req;
  logic        irq_pending;
  logic        pc_en;
  logic [31:0] next_pc_if1;
  logic        flush_if;
  logic        redirect_pending;
  logic        wfi_active;

  int pass_count = 0;
  int total_count = 0;

  pc_sequencer #(.RESET_VECTOR(32'h0), .PC_STEP(32'd4)) dut (
    .clk(clk), .reset_n(reset_n), .stall_if1(stall_if1),
    .current_pc_if1(current_pc_if1), .br_redirect(br_redirect),
    .br_target(br_target), .mret_redirect(mret_redirect), .mepc(mepc),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .wfi_req(wfi_req),
    .irq_pending(irq_pending), .pc_en(pc_en), .next_pc_if1(next_pc_if1),
    .flush_if(flush_if), .redirect_pending(redirect_pending),
    .wfi_active(wfi_active)
  );

  always #5 clk = ~clk;

  // The PC register the sequencer drives; its reset value matches RESET_VECTOR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   current_pc_if1 <= 32'h0;
    else if (pc_en) current_pc_if1 <= next_pc_if1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic stall, input logic br, input logic [31:0] bt,
                               input logic mr, input logic [31:0] ep,
                               input logic tr, input logic [31:0] tv,
                               input logic wfi, input logic irq);
    stall_if1 = stall; br_redirect = br; br_target = bt; mret_redirect = mr;
    mepc = ep; trap_valid = tr; trap_vector = tv; wfi_req = wfi; irq_pending = irq;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic stall);
    applyStimulus(stall, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(0, 1, 32'h300, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("rst_pc_en", 32'(pc_en), 0);
    checkOutput("rst_next_pc", next_pc_if1, 32'h0);
    checkOutput("rst_flush", 32'(flush_if), 0);
    checkOutput("rst_pending", 32'(redirect_pending), 0);
    checkOutput("rst_wfi", 32'(wfi_active), 0);

    // Reset release: one BOOT cycle, then 4, 8, 12.
    nextCycle();
    reset_n = 1'b1;
    idle(0);
    #2;
    checkOutput("boot_pc_en", 32'(pc_en), 0);
    checkOutput("boot_next_pc", next_pc_if1, 32'h0);
    nextCycle(); #2;
    checkOutput("seq_4", next_pc_if1, 32'h4);
    checkOutput("seq_4_en", 32'(pc_en), 1);
    nextCycle(); #2;
    checkOutput("seq_8", next_pc_if1, 32'h8);
    nextCycle(); #2;
    checkOutput("seq_12", next_pc_if1, 32'hC);

    // All three redirect sources at once.
    nextCycle();
    applyStimulus(0, 1, 32'h300, 1, 32'h200, 1, 32'h100, 0, 0);
    #2;
    checkOutput("prio_next_pc", next_pc_if1, 32'h100);
    checkOutput("prio_flush", 32'(flush_if), 1);
    checkOutput("prio_pc_en", 32'(pc_en), 1);
    nextCycle();
    idle(0);
    #2;
    checkOutput("after_prio_seq", next_pc_if1, 32'h104);
    checkOutput("after_prio_flush", 32'(flush_if), 0);

    // Five stalled cycles: branch in cycle 1, trap in cycle 3.
    for (int c = 1; c <= 5; c++) begin
      nextCycle();
      if (c == 1)      applyStimulus(1, 1, 32'h40, 0, 0, 0, 0, 0, 0);
      else if (c == 3) applyStimulus(1, 0, 0, 0, 0, 1, 32'h80, 0, 0);
      else             idle(1);
      #2;
      checkOutput($sformatf("stall_c%0d_pc_en", c), 32'(pc_en), 0);
      checkOutput($sformatf("stall_c%0d_flush", c), 32'(flush_if),
                  (c == 1 || c == 3) ? 32'd1 : 32'd0);
      if (c >= 2)
        checkOutput($sformatf("stall_c%0d_pending", c), 32'(redirect_pending), 1);
    end
    nextCycle();
    idle(0);
    #2;
    checkOutput("release_next_pc", next_pc_if1, 32'h80);
    checkOutput("release_pc_en", 32'(pc_en), 1);
    checkOutput("release_flush", 32'(flush_if), 0);
    nextCycle(); #2;
    checkOutput("post_release_seq", next_pc_if1, 32'h84);

    // WFI with irq wake: PC held at 0x84, resumes sequentially.
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #2;
    checkOutput("wfi_entry_pc_en", 32'(pc_en), 0);
    for (int c = 0; c < 10; c++) begin
      nextCycle();
      if (c == 4) applyStimulus(0, 1, 32'h900, 1, 32'hA00, 0, 0, 0, 0);
      else        idle(0);
      #2;
      checkOutput($sformatf("wfi_c%0d_active", c), 32'(wfi_active), 1);
      checkOutput($sformatf("wfi_c%0d_pc_en", c), 32'(pc_en), 0);
      if (c == 4) checkOutput("wfi_ignore_br_flush", 32'(flush_if), 0);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    checkOutput("wfi_irq_pc_en", 32'(pc_en), 0);
    nextCycle();
    idle(0);
    #2;
    checkOutput("wfi_resume_seq", next_pc_if1, 32'h88);
    checkOutput("wfi_resume_active", 32'(wfi_active), 0);

    // WFI exited by trap.
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    nextCycle();
    idle(0);
    #2;
    checkOutput("wfi2_active", 32'(wfi_active), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hC0, 0, 0);
    #2;
    checkOutput("wfi_trap_next_pc", next_pc_if1, 32'hC0);
    checkOutput("wfi_trap_pc_en", 32'(pc_en), 1);
    checkOutput("wfi_trap_flush", 32'(flush_if), 1);
    nextCycle();
    idle(0);
    #2;
    checkOutput("wfi_trap_seq", next_pc_if1, 32'hC4);

    // Wrap at the top of the address space, and target alignment.
    nextCycle();
    applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("br_top", next_pc_if1, 32'hFFFF_FFFC);
    nextCycle();
    idle(0);
    #2;
    checkOutput("wrap", next_pc_if1, 32'h0);
    nextCycle();
    applyStimulus(0, 1, 32'h1003, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("align", next_pc_if1, 32'h1000);
    nextCycle();
    idle(0);
    #2;
    checkOutput("align_seq", next_pc_if1, 32'h1004);

    // Redirect arriving on the stall-release cycle beats the held target.
    nextCycle();
    applyStimulus(1, 1, 32'h600, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 1, 32'h700, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("release_redirect_pc", next_pc_if1, 32'h700);
    checkOutput("release_redirect_flush", 32'(flush_if), 1);
    checkOutput("release_redirect_en", 32'(pc_en), 1);

    // Asynchronous reset while a redirect is held.
    nextCycle();
    applyStimulus(1, 1, 32'h500, 0, 0, 0, 0, 0, 0);
    nextCycle();
    idle(1);
    #1;
    checkOutput("hold_pending", 32'(redirect_pending), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_pending", 32'(redirect_pending), 0);
    checkOutput("async_rst_next_pc", next_pc_if1, 32'h0);
    checkOutput("async_rst_pc_en", 32'(pc_en), 0);
    nextCycle();
    reset_n = 1'b1;
    idle(0);
    #2;
    checkOutput("reboot_pc_en", 32'(pc_en), 0);
    checkOutput("reboot_next_pc", next_pc_if1, 32'h0);
    nextCycle(); #2;
    checkOutput("reboot_seq", next_pc_if1, 32'h4);
    checkOutput("reboot_pending", 32'(redirect_pending), 0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
